// File: rtl/cpu_pkg.sv
// Shared MCU core definitions.
//   PC_W        program counter width, passed to the call stack as AW
//   STACK_DEPTH return-address stack depth, passed as DEPTH
//   pc_t        program counter type
package cpu_pkg;

    localparam int PC_W        = 11;
    localparam int STACK_DEPTH = 8;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/call_stack.sv
// Hardware return-address stack for the MCU core (CALL/RETURN storage).
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   reset      asynchronous active-high reset, clears pointer, count, entries, flags
//   push       CALL strobe, stores push_addr as new top
//   pop        RETURN strobe, removes top entry
//   push_addr  return address to store
//   clr_err    clears sticky error flags (unused when error detection is compiled out)
//   top_addr   current top entry, combinational from storage
//   depth      number of valid entries, 0..DEPTH
//   full       depth == DEPTH
//   empty      depth == 0
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
//
// Build option CALL_STACK_ERR_EN: when defined, push-on-full and pop-on-empty are
// ignored and flagged. When undefined, the stack is circular (oldest entry is
// overwritten, pointer keeps moving on underflow) and the flags are tied low.
module call_stack
    import cpu_pkg::*;
#(
    parameter int AW    = PC_W,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_addr,
    input  logic                       clr_err,
    output logic [AW-1:0]              top_addr,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic [PW-1:0] wp_m1;
    logic          is_full;
    logic          is_empty;
    logic          push_eff;
    logic          pop_eff;
    logic          replace;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign wp_m1    = wp - 1'b1;
    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);

    assign top_addr = mem[wp_m1];
    assign depth    = cnt;
    assign full     = is_full;
    assign empty    = is_empty;

    // A push+pop on an empty stack has nothing to replace, so it degrades to a
    // plain push. A push+pop on a full stack is a legal replace in both builds.
    always_comb begin
        replace  = push && pop && !is_empty;
        push_eff = push && !(pop && !is_empty);
        pop_eff  = pop && !push;
`ifdef CALL_STACK_ERR_EN
        push_eff = push_eff && !is_full;
        pop_eff  = pop_eff && !is_empty;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_eff) begin
            mem[wp] <= push_addr;
            wp      <= wp + 1'b1;
            if (!is_full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (replace) begin
            mem[wp_m1] <= push_addr;
        end else if (pop_eff) begin
            wp <= wp_m1;
            if (!is_empty) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic ovf_q;
    logic unf_q;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && !pop && is_full) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (pop && !push && is_empty) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack. Stimulus pushes the hand-computed expected
// post-operation state into a queue; the monitor pops and compares after each
// clock edge (or on an explicit sample event for reset checks).
// Expectations follow the build: CALL_STACK_ERR_EN selects the trapping variant.
module tb_call_stack;
    import cpu_pkg::*;

`ifdef CALL_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    pc_t        push_addr = '0;
    logic       clr_err = 1'b0;
    pc_t        top_addr;
    logic [3:0] depth;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    call_stack #(.AW(PC_W), .DEPTH(STACK_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .clr_err   (clr_err),
        .top_addr  (top_addr),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        pc_t   top;
        int    dep;
        logic  ovf;
        logic  unf;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares every queued expectation shortly after the edge/event.
    initial begin
        forever begin
            @(posedge clk or sample_ev);
            #1;
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (top_addr !== e.top || depth !== 4'(e.dep) ||
                    full !== (e.dep == 8) || empty !== (e.dep == 0) ||
                    overflow !== e.ovf || underflow !== e.unf) begin
                    errors++;
                    $display("FAIL %s: got top=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want top=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                             e.name, top_addr, depth, full, empty, overflow, underflow,
                             e.top, e.dep, (e.dep == 8), (e.dep == 0), e.ovf, e.unf);
                end
            end
        end
    end

    task automatic op(input logic p, input logic o, input pc_t a, input logic c,
                      input string nm, input pc_t et, input int ed,
                      input logic eo, input logic eu);
        @(negedge clk);
        push = p; pop = o; push_addr = a; clr_err = c;
        @(posedge clk);
        q.push_back('{nm, et, ed, eo, eu});
    endtask

    task automatic expect_now(input string nm, input pc_t et, input int ed,
                              input logic eo, input logic eu);
        q.push_back('{nm, et, ed, eo, eu});
        -> sample_ev;
        #2;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        expect_now(nm, 11'h000, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 0;
        expect_now("reset_state", 11'h000, 0, 1'b0, 1'b0);

        // Basic LIFO order
        op(1, 0, 11'h010, 0, "push_010", 11'h010, 1, 0, 0);
        op(1, 0, 11'h020, 0, "push_020", 11'h020, 2, 0, 0);
        op(1, 0, 11'h030, 0, "push_030", 11'h030, 3, 0, 0);
        op(0, 1, 11'h000, 0, "pop_030",  11'h020, 2, 0, 0);
        op(0, 1, 11'h000, 0, "pop_020",  11'h010, 1, 0, 0);
        op(0, 1, 11'h000, 0, "pop_010",  11'h000, 0, 0, 0);

        // Pop on empty, clear, and set-wins-over-clear
        op(0, 1, 11'h000, 0, "pop_empty",   11'h000, 0, 0, ERR);
        op(0, 0, 11'h000, 1, "clr_err",     11'h000, 0, 0, 0);
        op(0, 1, 11'h000, 1, "pop_empty_clr", 11'h000, 0, 0, ERR);
        op(0, 0, 11'h000, 1, "clr_err2",    11'h000, 0, 0, 0);

        // Fill past capacity, replace while full, drain past empty
        do_reset("reset_sync");
        for (int k = 1; k <= 8; k++) begin
            op(1, 0, 11'(k), 0, $sformatf("fill_%0d", k), 11'(k), k, 0, 0);
        end
        op(1, 0, 11'h009, 0, "push_full", ERR ? 11'h008 : 11'h009, 8, ERR, 0);
        op(1, 1, 11'h0AA, 0, "replace_full", 11'h0AA, 8, ERR, 0);
        for (int i = 1; i <= 8; i++) begin
            pc_t t;
            if (i == 8) t = 11'h0AA;
            else        t = ERR ? 11'(8 - i) : 11'(9 - i);
            op(0, 1, 11'h000, 0, $sformatf("drain_%0d", i), t, 8 - i, ERR, 0);
        end
        op(0, 1, 11'h000, 0, "pop_empty_wrap", ERR ? 11'h0AA : 11'h008, 0, ERR, ERR);
        op(0, 0, 11'h000, 1, "clr_both", ERR ? 11'h0AA : 11'h008, 0, 0, 0);

        // Tail call at depth 2, and push+pop on empty
        do_reset("reset_tail");
        op(1, 0, 11'h100, 0, "push_100",  11'h100, 1, 0, 0);
        op(1, 0, 11'h200, 0, "push_200",  11'h200, 2, 0, 0);
        op(1, 1, 11'h300, 0, "tail_300",  11'h300, 2, 0, 0);
        op(0, 1, 11'h000, 0, "pop_300",   11'h100, 1, 0, 0);
        op(0, 1, 11'h000, 0, "pop_100",   11'h000, 0, 0, 0);
        op(1, 1, 11'h155, 0, "tail_empty", 11'h155, 1, 0, 0);
        op(0, 1, 11'h000, 0, "pop_155",   11'h000, 0, 0, 0);

        // Width extremes
        op(1, 0, 11'h7FF, 0, "push_7ff", 11'h7FF, 1, 0, 0);
        op(1, 0, 11'h000, 0, "push_000", 11'h000, 2, 0, 0);
        op(0, 1, 11'h000, 0, "pop_000",  11'h7FF, 1, 0, 0);
        op(0, 1, 11'h000, 0, "pop_7ff",  11'h000, 0, 0, 0);

        // Asynchronous reset mid-cycle at depth 5
        for (int k = 0; k < 5; k++) begin
            op(1, 0, 11'h011 + 11'(k), 0, $sformatf("pre_rst_%0d", k),
               11'h011 + 11'(k), k + 1, 0, 0);
        end
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0;
        #2;
        reset = 1;
        expect_now("async_reset", 11'h000, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 0;
        op(0, 0, 11'h000, 0, "post_reset_idle", 11'h000, 0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
